comb_sweep_controller: RTL
==========================

Name: comb_sweep_controller

Overview:
- Sequences a purely combinational benchmark netlist (13-in/22-out class, e.g. an original circuit and its resynthesised variant) through a test sweep.
- Drives input vectors, waits a programmable settle time, compares the DUT against a reference netlist, and compacts DUT outputs into a MISR signature.
- Sits between the dataset-generation harness and a pair of combinational netlists. Used to certify equivalence and signatures of each dataset entry.

Parameters:
- N_IN, 13, width of the stimulus vector driven to both netlists
- N_OUT, 22, width of the netlist output vectors
- SIG_W, 32, MISR signature width (must be ≥ N_OUT)
- POLY, 32'h04C1_1DB7, MISR/LFSR feedback polynomial (Galois form)
- SETTLE_CYC, 1, wait cycles between driving a vector and capturing (1..15)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a sweep; honoured only in IDLE
- abort  in  1  terminate the current sweep
- mode  in  1  0 = exhaustive (all 2^N_IN vectors), 1 = pseudo-random LFSR
- seed  in  N_IN  LFSR seed, sampled on start (mode=1)
- num_vec  in  N_IN+1  vector count for mode=1, sampled on start
- dut_in  out  N_IN  registered stimulus to both netlists
- dut_out  in  N_OUT  outputs of the netlist under test
- ref_out  in  N_OUT  outputs of the reference netlist
- busy  out  1  high from start-accept until DONE/abort
- done  out  1  one-cycle pulse at sweep completion
- mismatch  out  1  sticky: any compare failed in this sweep
- first_bad_vec  out  N_IN  dut_in value at the first mismatch
- bad_count  out  16  number of mismatching vectors, saturates at 16'hFFFF
- signature  out  SIG_W  MISR result, valid when done

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE; the MISR, vector counter and LFSR are 0.
- The FSM has four states: IDLE, DRIVE, SETTLE, CAPTURE.
- IDLE:
  - start=1 leads to DRIVE.
  - On entry to DRIVE: clear mismatch, bad_count, first_bad_vec and signature; set busy=1.
  - Load the vector source: mode 0 starts at 0; mode 1 loads seed, with a seed of 0 replaced by 1.
  - Load the remaining count: 2^N_IN for mode 0, num_vec for mode 1.
  - In mode 1, num_vec=0 completes immediately: done pulses the next cycle, signature=0, and no vector is driven.
- DRIVE: dut_in <= current vector, then go to SETTLE with the settle counter = SETTLE_CYC.
- SETTLE: decrement the counter each cycle; at 0 go to CAPTURE.
- CAPTURE:
  - MISR update: sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(dut_out).
  - If dut_out != ref_out: increment bad_count (saturating). If mismatch was 0, latch first_bad_vec <= dut_in. Set mismatch=1.
  - Advance the vector: mode 0 adds +1; mode 1 steps the LFSR (Galois, POLY truncated to N_IN bits).
  - Decrement the remaining count. If it reaches 0: go to IDLE, pulse done, clear busy. Otherwise return to DRIVE.
- Timing:
  - Per-vector cost is SETTLE_CYC+2 cycles.
  - done asserts N_VEC*(SETTLE_CYC+2) cycles after the start-accept edge.
  - Default exhaustive run: 8192*3 = 24576 cycles.
- Counter width: the exhaustive counter is N_IN+1 bits wide, so 2^N_IN is representable and there is no premature wrap. dut_in wraps 0x1FFF to 0 only internally, after the final vector.
- start while busy is ignored; it has no effect on state or results.
- abort:
  - Has priority over every state transition.
  - Next cycle: FSM to IDLE, busy=0, done stays 0.
  - Result outputs hold their partial values.
- Simultaneous start and abort in IDLE: abort wins and no sweep begins.
- rst_n low mid-sweep: every output and register returns to its reset value on that edge.
- Results (signature, mismatch, bad_count, first_bad_vec) hold until the next accepted start.

Decomposition:
- Shared package comb_sweep_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, CAPTURE);
  - the default POLY constant;
  - SETTLE_MAX = 15;
  - the BAD_CNT_W = 16 constant.
- One sub-module, sweep_misr (parameters SIG_W, N_OUT, POLY; inputs clr, en, data). It is reused by other dataset-certification blocks.
- The LFSR stays inline.

Test Plan:
- Identical netlists (ref_out tied to dut_out), mode 0, SETTLE_CYC=1 → busy is high for 24576 cycles, done pulses once, mismatch=0, bad_count=0, and the signature equals the golden model.
- ref_out differs only when dut_in==13'h00A5, mode 0 → mismatch=1, first_bad_vec=13'h00A5, bad_count=1.
- mode 1, seed=0, num_vec=5 → exactly 5 vectors are driven: 1 followed by 4 LFSR successors; done occurs at cycle 15.
- mode 1, num_vec=0 → done on the next cycle, signature=0, and dut_in never changes.
- abort at cycle 100 of a sweep → IDLE on cycle 101, done never pulses, and bad_count/signature hold their partial values.
- start pulsed at cycle 50 mid-sweep, then rst_n low at cycle 200 → the start has no effect; after reset all outputs are 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the combinational-netlist sweep controller.
package comb_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    localparam logic [31:0] DEF_POLY   = 32'h04C1_1DB7;
    localparam int          SETTLE_MAX = 15;
    localparam int          BAD_CNT_W  = 16;

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register: Galois shift with polynomial feedback,
// netlist outputs folded into the low bits on every enabled cycle.
module sweep_misr
    import comb_sweep_pkg::*;
#(
    parameter int               SIG_W = 32,
    parameter int               N_OUT = 22,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [N_OUT-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q, sig_d;

    // clear wins over compaction so a new sweep always starts from zero
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(data);
        end
    end

    // signature register, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/comb_sweep_controller.sv
// Sweeps stimulus vectors through a netlist under test and a reference
// netlist, counts miscompares and compacts the DUT outputs into a MISR.
module comb_sweep_controller
    import comb_sweep_pkg::*;
#(
    parameter int               N_IN       = 13,
    parameter int               N_OUT      = 22,
    parameter int               SIG_W      = 32,
    parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEF_POLY),
    parameter int               SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic [N_IN-1:0]      seed,
    input  logic [N_IN:0]        num_vec,
    output logic [N_IN-1:0]      dut_in,
    input  logic [N_OUT-1:0]     dut_out,
    input  logic [N_OUT-1:0]     ref_out,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic [N_IN-1:0]      first_bad_vec,
    output logic [BAD_CNT_W-1:0] bad_count,
    output logic [SIG_W-1:0]     signature
);

    localparam int              SC_W      = $clog2(SETTLE_MAX + 1);
    localparam int              REM_W     = N_IN + 1;
    localparam logic [N_IN-1:0] LFSR_TAPS = POLY[N_IN-1:0];

    state_e               state_q, state_d;
    logic [N_IN-1:0]      vec_q, vec_d;
    logic [N_IN-1:0]      dut_in_q, dut_in_d;
    logic [N_IN-1:0]      first_q, first_d;
    // one bit wider than the vector so a full 2^N_IN sweep is representable
    logic [REM_W-1:0]     rem_q, rem_d;
    logic [SC_W-1:0]      settle_q, settle_d;
    logic [BAD_CNT_W-1:0] bad_q, bad_d;
    logic                 mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 mm_q, mm_d;
    logic                 misr_clr, misr_en, miscompare;
    logic [N_IN-1:0]      lfsr_next;

    assign lfsr_next  = {vec_q[N_IN-2:0], 1'b0} ^ (vec_q[N_IN-1] ? LFSR_TAPS : '0);
    assign miscompare = (dut_out != ref_out);

    // next-state and datapath updates; abort overrides every transition
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        dut_in_d = dut_in_q;
        first_d  = first_q;
        rem_d    = rem_q;
        settle_d = settle_q;
        bad_d    = bad_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mm_d     = mm_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mm_d     = 1'b0;
                        bad_d    = '0;
                        first_d  = '0;
                        misr_clr = 1'b1;
                        mode_d   = mode;
                        vec_d    = mode ? ((seed == '0) ? N_IN'(1) : seed) : '0;
                        rem_d    = mode ? num_vec : {1'b1, {N_IN{1'b0}}};
                        // an empty pseudo-random sweep finishes without driving
                        if (mode && (num_vec == '0)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = DRIVE;
                            busy_d  = 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    dut_in_d = vec_q;
                    settle_d = SC_W'(SETTLE_CYC);
                    state_d  = SETTLE;
                end
                SETTLE: begin
                    settle_d = settle_q - SC_W'(1);
                    if (settle_d == '0) state_d = CAPTURE;
                end
                CAPTURE: begin
                    misr_en = 1'b1;
                    if (miscompare) begin
                        if (bad_q != '1) bad_d = bad_q + BAD_CNT_W'(1);
                        if (!mm_q)       first_d = dut_in_q;
                        mm_d = 1'b1;
                    end
                    vec_d = mode_q ? lfsr_next : vec_q + N_IN'(1);
                    rem_d = rem_q - REM_W'(1);
                    if (rem_d == '0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRIVE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q    <= '0;
            dut_in_q <= '0;
            first_q  <= '0;
            rem_q    <= '0;
            settle_q <= '0;
            bad_q    <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mm_q     <= 1'b0;
        end else begin
            vec_q    <= vec_d;
            dut_in_q <= dut_in_d;
            first_q  <= first_d;
            rem_q    <= rem_d;
            settle_q <= settle_d;
            bad_q    <= bad_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mm_q     <= mm_d;
        end
    end

    sweep_misr #(
        .SIG_W (SIG_W),
        .N_OUT (N_OUT),
        .POLY  (POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .data  (dut_out),
        .sig   (signature)
    );

    assign dut_in        = dut_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign mismatch      = mm_q;
    assign first_bad_vec = first_q;
    assign bad_count     = bad_q;

endmodule
